// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared types and constants for the nibble-serial adder controller.
//   state_t  : controller FSM encoding (IDLE, RUN, DONE)
//   NIBBLE_W : width of one adder slice
// Optional feature macro used by the slice: NIBBLE_SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
// Operand and result handshakes of the nibble-serial adder.
//   master : operand issuer / result consumer (drives in_*, out_ready)
//   slave  : the adder controller (drives in_ready, out_*, busy)
// Signals: in_valid/in_ready/in_a/in_b/in_cin, out_valid/out_ready/out_sum/
//          out_cout, busy; out_ovf only when NIBBLE_SERIAL_ADDER_OVF_EN is set.
// -----------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    import nibble_serial_adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , output out_ovf
`endif
    );

endinterface

// File: rtl/four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
// Combinational 4-bit adder slice with carry in/out.
//   a, b : slice operands
//   cin  : carry in
//   sum  : slice sum
//   cout : carry out of bit 3
// -----------------------------------------------------------------------------
module four_bit_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// One WIDTH-bit addition computed over NIBBLES cycles through a single
// four_bit_adder, least-significant nibble first, carry registered between
// slices.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of nibble_serial_adder_ctrl_if (operand and result
//          valid/ready handshakes, busy)
// Optional: NIBBLE_SERIAL_ADDER_OVF_EN adds bus.out_ovf, the signed overflow
// flag, captured with the last slice.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one nibble per cycle, idx selects the slice
// DONE  | result held on out_* with out_valid until out_ready
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    nibble_serial_adder_ctrl_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    // Operands and sum kept as nibble arrays so the active slice is a plain index.
    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

    state_t           state_q, state_d;
    word_t            a_q, a_d;
    word_t            b_q, b_d;
    word_t            sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;

    four_bit_adder u_adder (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    // add_sum[MSB] is the final sum MSB; sum_q is not yet updated.
                    ovf_d = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                            (add_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies decoded from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.busy      = busy_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed self-checking bench for nibble_serial_adder_ctrl with WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
// Honors NIBBLE_SERIAL_ADDER_OVF_EN for the overflow flag.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Starts at a falling edge with the block idle and out_ready high.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
        int cnt;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
        check({tag, ".in_ready_run"}, 32'(bus.in_ready), 32'd0);
        wait_valid(cnt);
        check({tag, ".latency"}, 32'(cnt), 32'd4);
        check({tag, ".sum"}, 32'(bus.out_sum), 32'(exp_sum));
        check({tag, ".cout"}, 32'(bus.out_cout), 32'(exp_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf expectation in %s", tag);
`endif
        @(negedge clk);
        check({tag, ".out_valid_fall"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [15:0] b2b_a   [3] = '{16'h1357, 16'hFFFF, 16'h8001};
    logic [15:0] b2b_b   [3] = '{16'h2468, 16'hFFFF, 16'h7FFF};
    logic        b2b_c   [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] b2b_s   [3] = '{16'h37BF, 16'hFFFF, 16'h0000};
    logic        b2b_co  [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int cnt;
        int w;
        int acc [3];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.out_sum", 32'(bus.out_sum), 32'd0);
        check("rst.out_cout", 32'(bus.out_cout), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("rst.out_ovf", 32'(bus.out_ovf), 32'd0);
`endif

        // Basic and boundary arithmetic
        do_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("cin_0fff",      16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        do_op("ovf_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held while out_ready low; extra in_valid ignored
        bus.out_ready = 1'b0;
        bus.in_a      = 16'hAAAA;
        bus.in_b      = 16'h5555;
        bus.in_cin    = 1'b1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(cnt);
        check("bp.latency", 32'(cnt), 32'd4);
        for (int i = 0; i < 6; i++) begin
            bus.in_a     = 16'h1111;
            bus.in_b     = 16'h1111;
            bus.in_cin   = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.sum", 32'(bus.out_sum), 32'h0000);
            check("bp.cout", 32'(bus.out_cout), 32'd1);
            check("bp.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.release_valid", 32'(bus.out_valid), 32'd0);
        check("bp.release_ready", 32'(bus.in_ready), 32'd1);
        check("bp.release_busy", 32'(bus.busy), 32'd0);

        // Reset in the third RUN cycle
        bus.in_a     = 16'hFFFF;
        bus.in_b     = 16'hFFFF;
        bus.in_cin   = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.out_sum", 32'(bus.out_sum), 32'd0);
        @(negedge clk);
        check("mid_rst.no_result", 32'(bus.out_valid), 32'd0);
        do_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Back-to-back issue with in_valid held high
        bus.in_a     = b2b_a[0];
        bus.in_b     = b2b_b[0];
        bus.in_cin   = b2b_c[0];
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 30) begin
                @(negedge clk);
                w++;
            end
            acc[i] = cyc;
            @(negedge clk);
            if (i < 2) begin
                bus.in_a   = b2b_a[i+1];
                bus.in_b   = b2b_b[i+1];
                bus.in_cin = b2b_c[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            wait_valid(cnt);
            check("b2b.latency", 32'(cnt), 32'd4);
            check("b2b.sum", 32'(bus.out_sum), 32'(b2b_s[i]));
            check("b2b.cout", 32'(bus.out_cout), 32'(b2b_co[i]));
            if (i > 0) check("b2b.spacing", 32'(acc[i] - acc[i-1]), 32'd6);
        end
        @(negedge clk);
        check("b2b.end_valid", 32'(bus.out_valid), 32'd0);
        check("b2b.end_ready", 32'(bus.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
